// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampled SPI slave (all CKP/CPH modes) with a one-entry TX buffer.
module spi_slave_responder #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = 8'hFF
) (
  input  logic CLK,
  input  logic Reset,
  input  logic CKP,
  input  logic CPH,
  input  logic SCK,
  input  logic SS,
  input  logic MOSI,
  output logic MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic tx_valid,
  output logic tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic rx_valid,
  output logic underrun,
  output logic frame_err,
  output logic busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state_q;
  logic [2:0] sck_q, ss_q;
  logic [1:0] mosi_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_sr_q, rx_sr_q, rx_sr_d, buf_q;
  logic buf_full_q;
  logic sck_rise, sck_fall, ss_rise, ss_fall, lead, trail, sample, shift, accept;
  always_comb begin
    sck_rise = sck_q[1] & ~sck_q[2];
    sck_fall = ~sck_q[1] & sck_q[2];
    ss_rise = ss_q[1] & ~ss_q[2];
    ss_fall = ~ss_q[1] & ss_q[2];
    lead = CKP ? sck_fall : sck_rise;
    trail = CKP ? sck_rise : sck_fall;
    sample = CPH ? trail : lead;
    shift = CPH ? lead : trail;
    accept = tx_valid & ~buf_full_q;
    rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi_q[1]};
    cnt_d = cnt_q + 1'b1;
  end
  assign tx_ready = ~buf_full_q;
  assign busy = state_q != IDLE;
  assign MISO = ~ss_q[1] & tx_sr_q[WIDTH-1];
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      sck_q <= '0;
      ss_q <= '1;
      mosi_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      buf_q <= '0;
      buf_full_q <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sck_q <= {sck_q[1:0], SCK};
      ss_q <= {ss_q[1:0], SS};
      mosi_q <= {mosi_q[0], MOSI};
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      frame_err <= 1'b0;
      buf_full_q <= state_q == LOAD ? accept : buf_full_q | accept;
      if (accept) buf_q <= tx_data;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (ss_fall) state_q <= LOAD;
        end
        LOAD: begin
          tx_sr_q <= buf_full_q ? buf_q : IDLE_WORD;
          underrun <= ~buf_full_q;
          state_q <= ss_rise ? IDLE : SHIFT;
        end
        default:
          if (ss_rise) begin
            frame_err <= cnt_q != '0;
            cnt_q <= '0;
            state_q <= IDLE;
          end else if (sample) begin
            rx_sr_q <= rx_sr_d;
            cnt_q <= cnt_d == FULL ? '0 : cnt_d;
            if (cnt_d == FULL) begin
              rx_data <= rx_sr_d;
              rx_valid <= 1'b1;
              state_q <= ss_q[1] ? IDLE : LOAD;
            end
          // a shift edge before any sample (or right after a word) would drop the freshly loaded MSB
          end else if (shift && cnt_q != '0) tx_sr_q <= tx_sr_q << 1;
      endcase
    end
endmodule
